// File: rtl/datamem_access_unit.sv
// datamem_access_unit: handshaked byte-enabled load/store responder for a slow data RAM.
// Optional DM_ALIGN_CHECK_EN: misaligned half/word accesses complete immediately with err.
`ifndef DM_OP_BIT
`define DM_OP_BIT 3
`endif
`ifndef DM_OP_SB
`define DM_OP_SB 3'd0
`endif
`ifndef DM_OP_SH
`define DM_OP_SH 3'd1
`endif
`ifndef DM_OP_WD
`define DM_OP_WD 3'd2
`endif
`ifndef DM_OP_UB
`define DM_OP_UB 3'd3
`endif
`ifndef DM_OP_UH
`define DM_OP_UH 3'd4
`endif

module datamem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [`DM_OP_BIT-1:0] req_op,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  stall,
    output logic [31:0]           rdata,
    output logic                  rdata_valid,
    output logic                  err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [29:0]           mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ack,
    input  logic [31:0]           mem_rdata
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  we_q, we_d, err_q, err_d;
    logic [`DM_OP_BIT-1:0] op_q, op_d;
    logic [31:0]           addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic                  is_b, is_h, misalign, busy;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [31:0]           load_data;
    logic [3:0]            store_be;

    assign is_b = (op_q == `DM_OP_SB) || (op_q == `DM_OP_UB);
    assign is_h = (op_q == `DM_OP_SH) || (op_q == `DM_OP_UH);
    assign busy = (state_q == BUSY);

`ifdef DM_ALIGN_CHECK_EN
    // Byte ops are never misaligned; anything not byte/half decodes as word.
    assign misalign = ((req_op == `DM_OP_SH) || (req_op == `DM_OP_UH)) ? req_addr[0] :
                      ((req_op == `DM_OP_SB) || (req_op == `DM_OP_UB)) ? 1'b0 :
                      (req_addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign byte_sel  = mem_rdata[8*addr_q[1:0] +: 8];
    assign half_sel  = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    assign load_data = (op_q == `DM_OP_SB) ? {{24{byte_sel[7]}}, byte_sel} :
                       (op_q == `DM_OP_UB) ? {24'd0, byte_sel} :
                       (op_q == `DM_OP_SH) ? {{16{half_sel[15]}}, half_sel} :
                       (op_q == `DM_OP_UH) ? {16'd0, half_sel} : mem_rdata;
    assign store_be  = is_b ? 4'b0001 << addr_q[1:0] :
                       is_h ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (req_valid) begin
                we_d    = req_we;
                op_d    = req_op;
                addr_d  = req_addr;
                wdata_d = req_wdata;
                cnt_d   = '0;
                err_d   = misalign;
                rdata_d = 32'd0;
                state_d = misalign ? DONE : BUSY;
            end
            BUSY: begin
                cnt_d = cnt_q + 1'b1;
                // ack takes priority over a coincident timeout
                if (mem_ack) begin
                    rdata_d = we_q ? 32'd0 : load_data;
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                    rdata_d = 32'd0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            op_q    <= '0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign stall       = busy || ((state_q == IDLE) && req_valid);
    assign rdata       = rdata_q;
    assign rdata_valid = (state_q == DONE);
    assign err         = (state_q == DONE) && err_q;
    assign mem_req     = busy;
    assign mem_we      = busy && we_q;
    assign mem_be      = busy ? (we_q ? store_be : 4'b1111) : 4'b0000;
    assign mem_addr    = addr_q[31:2];
    assign mem_wdata   = is_b ? {4{wdata_q[7:0]}} : is_h ? {2{wdata_q[15:0]}} : wdata_q;
endmodule

// File: tb/tb_datamem_access_unit.sv
// tb_datamem_access_unit: directed vectors with a completion scoreboard for datamem_access_unit.
`ifndef DM_OP_BIT
`define DM_OP_BIT 3
`endif
`ifndef DM_OP_SB
`define DM_OP_SB 3'd0
`endif
`ifndef DM_OP_SH
`define DM_OP_SH 3'd1
`endif
`ifndef DM_OP_WD
`define DM_OP_WD 3'd2
`endif
`ifndef DM_OP_UB
`define DM_OP_UB 3'd3
`endif
`ifndef DM_OP_UH
`define DM_OP_UH 3'd4
`endif

module tb_datamem_access_unit;
    logic                  clk = 0, rst = 1;
    logic                  req_valid = 0, req_we = 0;
    logic [`DM_OP_BIT-1:0] req_op = '0;
    logic [31:0]           req_addr = 0, req_wdata = 0;
    logic                  stall, rdata_valid, err, mem_req, mem_we;
    logic [31:0]           rdata, mem_wdata;
    logic [3:0]            mem_be;
    logic [29:0]           mem_addr;
    logic                  mem_ack = 0;
    logic [31:0]           mem_rdata = 0;

    int vectors = 0, miscompares = 0;
    logic [32:0] sb_q[$];

    localparam logic [31:0] RD = 32'h80F0_7F81;

    datamem_access_unit #(.TIMEOUT_CYCLES(4), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall), .rdata(rdata),
        .rdata_valid(rdata_valid), .err(err), .mem_req(mem_req), .mem_we(mem_we),
        .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every completion strobe must match the oldest expected response.
    always @(negedge clk) begin
        if (!rst && rdata_valid) begin
            if (sb_q.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
            else begin
                logic [32:0] e;
                e = sb_q.pop_front();
                chk("rdata", rdata, e[32:1]);
                chk("err", {31'd0, err}, {31'd0, e[0]});
            end
        end
    end

    task automatic access(input logic we, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wd, input int lat, input logic [3:0] ebe,
                          input logic [31:0] ewd, input logic [31:0] erd, input logic eerr,
                          input int ebusy);
        int nbusy;
        @(posedge clk); #1;
        req_valid = 1; req_we = we; req_op = op; req_addr = addr; req_wdata = wd;
        sb_q.push_back({erd, eerr});
        #1 chk("stall_req", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        req_valid = 0; req_op = `DM_OP_SB; req_addr = 32'hDEAD_BEEF; req_wdata = 32'h0;
        nbusy = 0;
        while (mem_req && nbusy < 40) begin
            nbusy++;
            if (nbusy == 1) begin
                chk("mem_be", {28'd0, mem_be}, {28'd0, ebe});
                chk("mem_addr", {2'd0, mem_addr}, {2'd0, addr[31:2]});
                chk("mem_we", {31'd0, mem_we}, {31'd0, we});
                if (we) chk("mem_wdata", mem_wdata, ewd);
            end
            chk("stall_busy", {31'd0, stall}, 32'd1);
            mem_ack = (nbusy == lat); mem_rdata = RD;
            @(posedge clk); #1;
            mem_ack = 0;
        end
        chk("busy_cycles", nbusy, ebusy);
        chk("stall_done", {31'd0, stall}, 32'd0);
        chk("valid_done", {31'd0, rdata_valid}, 32'd1);
    endtask

    initial begin
        #1;
        chk("rst_stall", {31'd0, stall}, 0);
        chk("rst_valid", {31'd0, rdata_valid}, 0);
        chk("rst_err", {31'd0, err}, 0);
        chk("rst_mem_req", {31'd0, mem_req}, 0);
        chk("rst_mem_we", {31'd0, mem_we}, 0);
        chk("rst_mem_be", {28'd0, mem_be}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_mem_addr", {2'd0, mem_addr}, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        @(posedge clk); #1 rst = 0;

        // stores: SB to 0x1003, SH to 0x2002, WD to 0x3000
        access(1, `DM_OP_SB, 32'h1003, 32'h0000_00A5, 1, 4'b1000, 32'hA5A5_A5A5, 0, 0, 1);
        access(1, `DM_OP_SH, 32'h2002, 32'h1234_BEEF, 2, 4'b1100, 32'hBEEF_BEEF, 0, 0, 2);
        access(1, `DM_OP_WD, 32'h3000, 32'hCAFE_F00D, 1, 4'b1111, 32'hCAFE_F00D, 0, 0, 1);
        // loads from word 0x80F07F81
        access(0, `DM_OP_SB, 32'h1000, 0, 1, 4'b1111, 0, 32'hFFFF_FF81, 0, 1);
        access(0, `DM_OP_UB, 32'h1001, 0, 1, 4'b1111, 0, 32'h0000_007F, 0, 1);
        access(0, `DM_OP_UB, 32'h1003, 0, 1, 4'b1111, 0, 32'h0000_0080, 0, 1);
        access(0, `DM_OP_SH, 32'h1002, 0, 1, 4'b1111, 0, 32'hFFFF_80F0, 0, 1);
        access(0, `DM_OP_SH, 32'h1000, 0, 1, 4'b1111, 0, 32'h0000_7F81, 0, 1);
        access(0, `DM_OP_UH, 32'h1002, 0, 1, 4'b1111, 0, 32'h0000_80F0, 0, 1);
        access(0, `DM_OP_WD, 32'h1000, 0, 1, 4'b1111, 0, RD, 0, 1);
        access(0, 3'd7, 32'h1000, 0, 1, 4'b1111, 0, RD, 0, 1);
        // 3-cycle latency, back-to-back lw then sw
        access(0, `DM_OP_WD, 32'h4000, 0, 3, 4'b1111, 0, RD, 0, 3);
        access(1, `DM_OP_WD, 32'h4004, 32'h1111_2222, 3, 4'b1111, 32'h1111_2222, 0, 0, 3);
        // timeout, then ack in the last allowed cycle
        access(0, `DM_OP_WD, 32'h5000, 0, 0, 4'b1111, 0, 0, 1, 4);
        access(0, `DM_OP_WD, 32'h5000, 0, 4, 4'b1111, 0, RD, 0, 4);
`ifdef DM_ALIGN_CHECK_EN
        access(0, `DM_OP_WD, 32'h1002, 0, 1, 4'b1111, 0, 0, 1, 0);
        access(0, `DM_OP_UH, 32'h1001, 0, 1, 4'b1111, 0, 0, 1, 0);
`else
        access(0, `DM_OP_WD, 32'h1002, 0, 1, 4'b1111, 0, RD, 0, 1);
        access(0, `DM_OP_UH, 32'h1001, 0, 1, 4'b1111, 0, 32'h0000_7F81, 0, 1);
`endif

        // reset mid-BUSY, then a stray ack must be ignored
        @(posedge clk); #1;
        req_valid = 1; req_we = 0; req_op = `DM_OP_WD; req_addr = 32'h40;
        @(posedge clk); #1 req_valid = 0;
        chk("busy_before_rst", {31'd0, mem_req}, 1);
        #2 rst = 1;
        #1 chk("rst_mem_req_async", {31'd0, mem_req}, 0);
        chk("rst_stall_async", {31'd0, stall}, 0);
        @(posedge clk); #1 rst = 0; mem_ack = 1; mem_rdata = RD;
        @(posedge clk); #1 mem_ack = 0;
        chk("stray_ack_valid", {31'd0, rdata_valid}, 0);
        chk("stray_ack_req", {31'd0, mem_req}, 0);
        repeat (3) @(posedge clk);
        chk("sb_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/datamem_access_unit.md
Name: datamem_access_unit

Overview:
- Memory-stage responder for the data-memory control signals produced by the instruction decoder: `op_datamem`, `w_en_datamem`, and the load path selected by `MUX_RF_DATAW_DM`.
- Turns a pipeline load/store request into a handshaked, byte-enabled word access on a slow external data RAM.
- Returns sign- or zero-extended load data and stalls the pipeline until the access completes or times out.

Parameters:
- TIMEOUT_CYCLES, 255: number of BUSY cycles without `mem_ack` before the access is aborted with `err`.
- CNT_WIDTH, 8: width of the timeout counter; must satisfy 2^CNT_WIDTH > TIMEOUT_CYCLES.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- req_valid  input  1  MEM stage holds a load or store instruction.
- req_we  input  1  store when 1, load when 0 (from `w_en_datamem`).
- req_op  input  `DM_OP_BIT  access type: `DM_OP_SB`, `DM_OP_SH`, `DM_OP_WD`, `DM_OP_UB` or `DM_OP_UH` (Core.vh).
- req_addr  input  32  byte address (ALU result).
- req_wdata  input  32  store data (register file port B).
- stall  output  1  freezes upstream pipeline stages.
- rdata  output  32  extended load result.
- rdata_valid  output  1  one-cycle completion strobe.
- err  output  1  one-cycle strobe for an aborted access.
- mem_req  output  1  external request.
- mem_we  output  1  external write enable.
- mem_be  output  4  byte lane enables; bit i = bits [8i+7:8i].
- mem_addr  output  30  word address = addr[31:2].
- mem_wdata  output  32  lane-replicated store data.
- mem_ack  input  1  external completion, valid for one cycle.
- mem_rdata  input  32  read word, valid with `mem_ack`.

Behaviour:
- Reset (asynchronous, effective immediately, including mid-access):
  - state IDLE; counter 0.
  - `stall`, `rdata_valid`, `err`, `mem_req`, `mem_we` = 0; `mem_be` = 0; `rdata`, `mem_addr`, `mem_wdata` = 0.
  - A `mem_ack` arriving after reset is ignored.
- States: IDLE, BUSY, DONE.
- IDLE:
  - On `req_valid`=1, latch we/op/addr/wdata, clear the counter, go to BUSY.
  - `stall` = `req_valid` (combinational).
- BUSY:
  - `mem_req`=1, with `mem_we`/`mem_be`/`mem_addr`/`mem_wdata` driven from the latched request and held stable; `stall`=1.
  - The counter increments each cycle.
  - `mem_ack`=1: capture the extracted load data and go to DONE.
  - Counter reaches TIMEOUT_CYCLES without ack: set `rdata`=0, flag err, go to DONE.
  - `mem_ack` and timeout in the same cycle: ack wins, no err.
- DONE:
  - `stall`=0 and `rdata_valid`=1 for exactly one cycle; `err`=1 in this cycle if aborted.
  - Always returns to IDLE; the pipeline advances on this edge, so the next request is accepted from IDLE.
  - Back-to-back access cost = 2 cycles + RAM latency.
- `mem_ack` outside BUSY is ignored.
- Stores:
  - SB: `mem_be` = 1<<addr[1:0]; `mem_wdata` = {4{wdata[7:0]}}.
  - SH: `mem_be` = addr[1] ? 4'b1100 : 4'b0011; `mem_wdata` = {2{wdata[15:0]}}.
  - WD: `mem_be` = 4'b1111; `mem_wdata` = wdata.
  - `rdata` is 0 on store completion.
- Loads:
  - `mem_be` = 4'b1111 and `mem_we`=0.
  - Lane selected by addr[1:0] (bytes) or addr[1] (halves).
  - SB sign-extends; UB zero-extends; SH sign-extends; UH zero-extends; WD passes the word through.
- `req_op`/`req_addr` changes while BUSY have no effect.
- Unknown `req_op` encodings are treated as WD.

Optional Feature:
- Macro: DM_ALIGN_CHECK_EN.
- Defined:
  - Misaligned accesses are SH/UH with addr[0]=1, or WD with addr[1:0]≠0.
  - A misaligned access goes IDLE→DONE directly: `mem_req` is never asserted, `err`=1, `rdata`=0, `stall` lasts 1 cycle.
- Undefined:
  - No checking; halfword accesses ignore addr[0] and word accesses ignore addr[1:0].

Test Plan:
- Reset asserted mid-BUSY (`mem_req`=1) → `mem_req`, `stall` drop immediately; a following `mem_ack` produces no `rdata_valid`.
- SB: addr 0x1003, wdata 0x000000A5 → `mem_be`=1000, `mem_wdata`=0xA5A5A5A5, `mem_addr`=0x400; `rdata_valid` in the cycle after ack.
- Load with `mem_rdata`=0x80F0_7F81:
  - SB @+0 → 0xFFFFFF81; UB @+1 → 0x0000007F.
  - SH @+2 → 0xFFFF80F0; UH @+2 → 0x000080F0; WD → 0x80F07F81.
- Ack latency 3 cycles → `stall` high 4 cycles (IDLE request cycle + 3 BUSY), then DONE; back-to-back lw/sw both complete in order.
- Timeout: no ack with TIMEOUT_CYCLES=4 → DONE after 4 BUSY cycles, `err`=1, `rdata`=0. Ack in the 4th BUSY cycle → no err.
- DM_ALIGN_CHECK_EN: WD at 0x1002 → `mem_req` never asserted, `err`=1 one cycle later. Without the macro → normal access to word 0x400 with `mem_be`=1111.
